// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - shared types and constants for the data-memory responder
package dmem_pkg;

  typedef enum logic [1:0] {
    SZ_B   = 2'b00,
    SZ_H   = 2'b01,
    SZ_W   = 2'b10,
    SZ_ILL = 2'b11
  } size_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

  localparam int LAT_W = 4;

endpackage

// File: rtl/dmem_lane_align.sv
// rtl/dmem_lane_align.sv - byte-lane strobes, store replication and load extraction
module dmem_lane_align
  import dmem_pkg::*;
(
  input  logic [1:0]  addr_lo,
  input  size_e       size,
  input  logic        is_unsigned,
  input  logic [31:0] wdata,
  input  logic [31:0] rword,
  output logic [3:0]  strb,
  output logic [31:0] wword,
  output logic [31:0] ld_data,
  output logic        misalign
);

  logic [31:0] shifted;

  assign shifted  = rword >> {addr_lo, 3'b000};
  assign misalign = ((size == SZ_H) && addr_lo[0]) ||
                    ((size == SZ_W) && (addr_lo != 2'b00));

  always_comb begin
    strb    = 4'b0000;
    wword   = wdata;
    ld_data = shifted;
    case (size)
      SZ_B: begin
        strb    = 4'b0001 << addr_lo;
        wword   = {4{wdata[7:0]}};
        ld_data = {{24{~is_unsigned & shifted[7]}}, shifted[7:0]};
      end
      SZ_H: begin
        strb    = 4'b0011 << addr_lo;
        wword   = {2{wdata[15:0]}};
        ld_data = {{16{~is_unsigned & shifted[15]}}, shifted[15:0]};
      end
      SZ_W: begin
        strb    = 4'b1111;
      end
      default: begin
        strb    = 4'b0000;
      end
    endcase
  end

endmodule

// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - load/store target with fixed latency and an internal word array
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int LATENCY     = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

  state_e            state;
  logic [LAT_W-1:0]  cnt;
  logic [31:0]       a_addr;
  size_e             a_size;
  logic              a_uns;
  logic              a_we;
  logic [31:0]       a_wdata;

  logic [31:0]       mem [DEPTH_WORDS];
  logic [AW-1:0]     widx;
  logic [31:0]       rword;
  logic [3:0]        strb;
  logic [31:0]       wword;
  logic [31:0]       ld_data;
  logic              misalign;
  logic              err;
  logic              commit;

  assign widx  = a_addr[AW+1:2];
  assign rword = mem[widx];
  assign err   = misalign || (a_size == SZ_ILL) ||
                 (a_addr[31:2] >= 30'(DEPTH_WORDS));
  // The last WAIT cycle is the edge that enters RESP, so the store commits there.
  assign commit    = (state == WAIT) && (cnt == '0);
  assign req_ready = (state == IDLE);

  dmem_lane_align u_align (
    .addr_lo     (a_addr[1:0]),
    .size        (a_size),
    .is_unsigned (a_uns),
    .wdata       (a_wdata),
    .rword       (rword),
    .strb        (strb),
    .wword       (wword),
    .ld_data     (ld_data),
    .misalign    (misalign)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      cnt       <= '0;
      a_addr    <= '0;
      a_size    <= SZ_B;
      a_uns     <= 1'b0;
      a_we      <= 1'b0;
      a_wdata   <= '0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            a_addr  <= req_addr;
            a_size  <= size_e'(req_size);
            a_uns   <= req_unsigned;
            a_we    <= req_we;
            a_wdata <= req_wdata;
            cnt     <= LAT_W'(LATENCY - 1);
            state   <= WAIT;
          end
        end
        WAIT: begin
          if (cnt == '0) begin
            state     <= RESP;
            rsp_valid <= 1'b1;
            rsp_err   <= err;
            rsp_rdata <= (err || a_we) ? 32'h0 : ld_data;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            state     <= IDLE;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (commit && a_we && !err) begin
      for (int b = 0; b < 4; b++) begin
        if (strb[b]) mem[widx][8*b +: 8] <= wword[8*b +: 8];
      end
    end
  end

endmodule
